// File: rtl/router_pkg.sv
// Shared sizing helpers and saturating counter arithmetic for the round-robin route switch.
package router_pkg;

    function automatic int dest_width(input int nout);
        return $clog2(nout) + 1;
    endfunction

    function automatic int src_width(input int nch);
        return (nch > 1) ? $clog2(nch) : 1;
    endfunction

    // Pointer resets to the last channel so the first search starts at channel 0.
    function automatic int ptr_reset(input int nch);
        return nch - 1;
    endfunction

    function automatic logic [31:0] sat_add(input logic [31:0] cnt, input logic [31:0] inc,
                                            input int cntw);
        logic [32:0] sum;
        logic [32:0] lim;
        sum = {1'b0, cnt} + {1'b0, inc};
        lim = (33'd1 << cntw) - 33'd1;
        return (sum > lim) ? 32'(lim) : 32'(sum);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter for one output port; owns its priority pointer.
module rr_arbiter
    import router_pkg::*;
#(
    parameter int NCH  = 4,
    parameter int SRCW = src_width(NCH)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NCH-1:0]  req,
    input  logic            advance,
    output logic [NCH-1:0]  gnt,
    output logic [SRCW-1:0] gnt_idx
);

    localparam logic [SRCW-1:0] PTR_RST = SRCW'(ptr_reset(NCH));

    logic [SRCW-1:0] r_ptr;
    logic            w_found;
    int              w_cand;

    // Search upward from the channel after the last winner, wrapping to 0.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        w_found = 1'b0;
        w_cand  = 0;
        for (int k = 1; k <= NCH; k++) begin
            w_cand = (int'(r_ptr) + k) % NCH;
            if (!w_found && req[w_cand]) begin
                w_found      = 1'b1;
                gnt[w_cand]  = 1'b1;
                gnt_idx      = SRCW'(w_cand);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= PTR_RST;
        end else if (advance) begin
            r_ptr <= gnt_idx;
        end
    end

endmodule

// File: rtl/rr_route_switch.sv
// NCH-to-NOUT valid/ready switch: per-port round-robin arbitration into one-entry output
// registers; words with an out-of-range destination are accepted, dropped and counted.
module rr_route_switch
    import router_pkg::*;
#(
    parameter int NCH   = 4,
    parameter int NOUT  = 3,
    parameter int DW    = 8,
    parameter int DESTW = dest_width(NOUT),
    parameter int SRCW  = src_width(NCH),
    parameter int CNTW  = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NCH-1:0]       in_valid,
    output logic [NCH-1:0]       in_ready,
    input  logic [NCH*DESTW-1:0] in_dest,
    input  logic [NCH*DW-1:0]    in_data,
    output logic [NOUT-1:0]      out_valid,
    input  logic [NOUT-1:0]      out_ready,
    output logic [NOUT*DW-1:0]   out_data,
    output logic [NOUT*SRCW-1:0] out_src,
    output logic                 err_pulse,
    output logic [CNTW-1:0]      drop_cnt
);

    logic [NCH-1:0]  w_illegal;
    logic [NCH-1:0]  w_req  [NOUT];
    logic [NCH-1:0]  w_gnt  [NOUT];
    logic [SRCW-1:0] w_gidx [NOUT];
    logic [NOUT-1:0] w_can_load;
    logic [NOUT-1:0] w_take;
    logic [SRCW:0]   w_ndrop;
    logic            r_err;
    logic [CNTW-1:0] r_cnt;

    always_comb begin
        w_illegal = '0;
        for (int p = 0; p < NOUT; p++) begin
            w_req[p] = '0;
        end
        for (int i = 0; i < NCH; i++) begin
            w_illegal[i] = in_valid[i] & (in_dest[i*DESTW +: DESTW] >= DESTW'(NOUT));
            for (int p = 0; p < NOUT; p++) begin
                w_req[p][i] = in_valid[i] & (in_dest[i*DESTW +: DESTW] == DESTW'(p));
            end
        end
    end

    // Illegal words are always accepted; legal ones only when granted into a loadable port.
    always_comb begin
        in_ready = w_illegal;
        for (int p = 0; p < NOUT; p++) begin
            in_ready = in_ready | (w_gnt[p] & {NCH{w_can_load[p]}});
        end
    end

    always_comb begin
        w_ndrop = '0;
        for (int i = 0; i < NCH; i++) begin
            w_ndrop = w_ndrop + (SRCW+1)'(w_illegal[i]);
        end
    end

    for (genvar p = 0; p < NOUT; p++) begin : g_port
        logic            r_valid;
        logic [DW-1:0]   r_data;
        logic [SRCW-1:0] r_src;

        assign w_can_load[p] = ~r_valid | out_ready[p];
        assign w_take[p]     = w_can_load[p] & (|w_gnt[p]);

        rr_arbiter #(
            .NCH  (NCH),
            .SRCW (SRCW)
        ) u_arb (
            .clk     (clk),
            .rst_n   (rst_n),
            .req     (w_req[p]),
            .advance (w_take[p]),
            .gnt     (w_gnt[p]),
            .gnt_idx (w_gidx[p])
        );

        // Load and drain on the same edge keeps the register full with the new word.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_valid <= 1'b0;
                r_data  <= '0;
                r_src   <= '0;
            end else if (w_take[p]) begin
                r_valid <= 1'b1;
                r_data  <= in_data[int'(w_gidx[p])*DW +: DW];
                r_src   <= w_gidx[p];
            end else if (out_ready[p]) begin
                r_valid <= 1'b0;
            end
        end

        assign out_valid[p]              = r_valid;
        assign out_data[p*DW +: DW]      = r_data;
        assign out_src[p*SRCW +: SRCW]   = r_src;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
            r_cnt <= '0;
        end else begin
            r_err <= |w_illegal;
            r_cnt <= CNTW'(sat_add(32'(r_cnt), 32'(w_ndrop), CNTW));
        end
    end

    assign err_pulse = r_err;
    assign drop_cnt  = r_cnt;

endmodule
